vga_video_driver: RTL and testbench

- 640x480@60 VGA timing generator and output stage, combined with a programmable slow-tick clock divider.
- Sits between the game/render logic and the board's VGA DAC pins.
- Derives the 25 MHz pixel clock from the 50 MHz system clock.
- Gates the caller's RGB with blanking and produces the sync signals.
- Also generates the game-rate clock new_clk from a runtime divisor.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/clk_divider.sv | 40 ++++
 rtl/vga_video_driver.sv | 156 +++++++++++++++
 tb/tb_vga_video_driver.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and pixel helpers for the 640x480@60 VGA driver.
// Optional build macro: TEST_PATTERN_EN (colour-bar generator in place of the
// caller's RGB). It is consumed by vga_video_driver.sv.
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks.
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    // Vertical timing, in lines.
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    // Width of the slow-tick divisor and its counter.
    localparam int DIV_W = 26;

    // Each line/frame starts with sync, then back porch, visible, front porch.
    localparam int H_TOTAL     = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOTAL     = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
    localparam int H_ACT_START = H_SYNC + H_BACK;
    localparam int V_ACT_START = V_SYNC + V_BACK;

    // One pixel worth of colour.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Colour of test bar k: each index bit drives one channel fully on or off.
    function automatic rgb_t bar_color(input logic [2:0] k);
        rgb_t c;
        c.r = {8{k[2]}};
        c.g = {8{k[1]}};
        c.b = {8{k[0]}};
        return c;
    endfunction

endpackage

// File: rtl/clk_divider.sv
// Runtime-programmable slow clock: new_clk toggles every div clk cycles, so
// its period is 2*div cycles. div of 0 or 1 toggles on every clk.
module clk_divider #(
    parameter int DIV_W = vga_timing_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    output logic             new_clk
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] limit;

    // Terminal count; div==0 is clamped so it behaves like div==1 instead of
    // wrapping to an all-ones limit.
    // NOTE: every always_comb output gets its value on every path, so no latch is inferred.
    always_comb begin
        limit = '0;
        if (div != '0) begin
            limit = div - 1'b1;
        end
    end

    // Count up to the limit, then restart and flip the output. The >= test
    // lets a divisor lowered mid-count take effect on the very next cycle.
    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            new_clk <= 1'b0;
        end else if (cnt >= limit) begin
            cnt     <= '0;
            new_clk <= ~new_clk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_video_driver.sv
// VGA timing generator and DAC output stage plus the game-rate clock divider.
// The pixel clock is clk/2; position counters and the registered outputs all
// advance on the clk edge where VGA_CLK rises.
// Build option: define TEST_PATTERN_EN to replace red/green/blue with eight
// vertical colour bars; timing is unchanged.
module vga_video_driver #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter int DIV_W     = vga_timing_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic [7:0]       red,
    input  logic [7:0]       green,
    input  logic [7:0]       blue,
    output logic             new_clk,
    output logic             VGA_CLK,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B,
    output logic             VGA_SYNC_N,
    output logic             VGA_BLANK_N,
    output logic             VGA_HS,
    output logic             VGA_VS
);

    import vga_timing_pkg::rgb_t;
    import vga_timing_pkg::bar_color;

    // Geometry derived from the per-instance timing.
    localparam int H_LEN = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_LEN = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
    localparam int HW    = $clog2(H_LEN);
    localparam int VW    = $clog2(V_LEN);
    localparam int BAR_W = H_VISIBLE / 8;

    localparam logic [HW-1:0] H_LAST      = HW'(H_LEN - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_VIS_FIRST = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_VIS_LAST  = HW'(H_SYNC + H_BACK + H_VISIBLE - 1);

    localparam logic [VW-1:0] V_LAST      = VW'(V_LEN - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_VIS_FIRST = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_VIS_LAST  = VW'(V_SYNC + V_BACK + V_VISIBLE - 1);

    logic [HW-1:0] h_count;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_count;
    logic [VW-1:0] v_next;
    logic          pix_en;
    logic          h_sync_n;
    logic          v_sync_n;
    logic          visible;
    rgb_t          pix_rgb;

    // Composite sync is not used by the DAC.
    assign VGA_SYNC_N = 1'b0;

    // One-cycle strobe in the clk cycle that ends with a VGA_CLK rising edge.
    assign pix_en = ~VGA_CLK;

    // Game-rate clock.
    clk_divider #(
        .DIV_W (DIV_W)
    ) u_clk_divider (
        .clk     (clk),
        .reset   (reset),
        .div     (div),
        .new_clk (new_clk)
    );

    // Pixel clock: clk divided by two, low out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            VGA_CLK <= 1'b0;
        end else begin
            VGA_CLK <= ~VGA_CLK;
        end
    end

    // Position the counters move to on the next pixel strobe.
    always_comb begin
        h_next = h_count + 1'b1;
        v_next = v_count;
        if (h_count == H_LAST) begin
            h_next = '0;
            if (v_count == V_LAST) begin
                v_next = '0;
            end else begin
                v_next = v_count + 1'b1;
            end
        end
    end

    // Region decode of the next position, so outputs line up with counters.
    always_comb begin
        h_sync_n = (h_next >= H_SYNC_END);
        v_sync_n = (v_next >= V_SYNC_END);
        visible  = (h_next >= H_VIS_FIRST) && (h_next <= H_VIS_LAST) &&
                   (v_next >= V_VIS_FIRST) && (v_next <= V_VIS_LAST);
    end

`ifdef TEST_PATTERN_EN
    logic [HW-1:0] h_offset;
    logic [2:0]    bar;
    logic          unused_rgb;

    // The caller's colour is not displayed in this build.
    assign unused_rgb = ^{red, green, blue};

    // Colour bar under the next pixel; garbage outside the visible window is
    // masked by the output stage.
    always_comb begin
        h_offset = h_next - H_VIS_FIRST;
        bar      = 3'(32'(h_offset) / BAR_W);
        pix_rgb  = bar_color(bar);
    end
`else
    // Pass the render logic's colour straight through.
    always_comb begin
        pix_rgb = '{r: red, g: green, b: blue};
    end
`endif

    // Counters and DAC-facing registers, all stepped by the pixel strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count     <= '0;
            v_count     <= '0;
            VGA_HS      <= 1'b0;
            VGA_VS      <= 1'b0;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_en) begin
            h_count     <= h_next;
            v_count     <= v_next;
            VGA_HS      <= h_sync_n;
            VGA_VS      <= v_sync_n;
            VGA_BLANK_N <= visible;
            VGA_R       <= visible ? pix_rgb.r : 8'h00;
            VGA_G       <= visible ? pix_rgb.g : 8'h00;
            VGA_B       <= visible ? pix_rgb.b : 8'h00;
        end
    end

endmodule

// File: tb/tb_vga_video_driver.sv
// Self-checking bench for vga_video_driver. Runs the DUT with a shrunken
// screen geometry so whole frames fit in a short run; expected values come
// from a position model computed from the pixel-rise count.
module tb_vga_video_driver;

    localparam int DIV_W = 26;

    // Reduced geometry: 50 pixels per line, 13 lines per frame.
    localparam int HV  = 32;
    localparam int HF  = 4;
    localparam int HS  = 8;
    localparam int HB  = 6;
    localparam int VV  = 6;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int HT  = HS + HB + HV + HF;
    localparam int VT  = VS + VB + VV + VF;
    localparam int HAS = HS + HB;
    localparam int VAS = VS + VB;
    localparam int FRAME = HT * VT;

    logic             clk = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] div;
    logic [7:0]       red, green, blue;
    logic             new_clk, VGA_CLK, VGA_SYNC_N, VGA_BLANK_N, VGA_HS, VGA_VS;
    logic [7:0]       VGA_R, VGA_G, VGA_B;

    int errors = 0;
    int checks = 0;

    vga_video_driver #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .DIV_W     (DIV_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .div         (div),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .new_clk     (new_clk),
        .VGA_CLK     (VGA_CLK),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [DIV_W-1:0] div;
        int               half;
    } div_vec_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Hold reset for three clk cycles; release lands on a falling edge.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Expected outputs after p pixel rises since reset release.
    function automatic void model(input int p, input color_t c, output logic e_hs, output logic e_vs,
                                  output logic e_bl, output logic [23:0] e_rgb);
        int h, v, k;
        h     = p % HT;
        v     = (p / HT) % VT;
        e_hs  = (h >= HS);
        e_vs  = (v >= VS);
        e_bl  = (h >= HAS) && (h < HAS + HV) && (v >= VAS) && (v < VAS + VV);
        k     = (h - HAS) / (HV / 8);
`ifdef TEST_PATTERN_EN
        e_rgb = e_bl ? {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}} : 24'h0;
`else
        k     = 0;
        e_rgb = e_bl ? {c.r, c.g, c.b} : 24'h0 + 24'(k);
`endif
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        div_vec_t dv[5];
        color_t   cv[3];
        int       t1, t2, p, rises, bad, first_bad;
        logic     lvl, prev, prev_vclk, prev_hs, prev_vs, prev_bl, rise;
        logic     e_hs, e_vs, e_bl;
        logic [23:0] e_rgb;
        int       hs_f1, hs_f2, hs_r, vs_f1, vs_f2, vs_r;
        int       bl_pix, bl_runs, run, max_run;
        localparam int TARGET = 6 * HT + 20;  // h=20, v=6: inside the visible window

        dv[0] = '{div: 26'd5, half: 5};
        dv[1] = '{div: 26'd1, half: 1};
        dv[2] = '{div: 26'd0, half: 1};
        dv[3] = '{div: 26'd3, half: 3};
        dv[4] = '{div: 26'd2, half: 2};

        cv[0] = '{r: 8'hAA, g: 8'h55, b: 8'hFF};
        cv[1] = '{r: 8'h12, g: 8'h34, b: 8'h56};
        cv[2] = '{r: 8'hFF, g: 8'h00, b: 8'h80};

        reset = 1'b1;
        div   = 26'd5;
        red   = 8'h00;
        green = 8'h00;
        blue  = 8'h00;
        #1;
        check("reset outputs", {new_clk, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, 64'h0);
        check("sync_n tied low", VGA_SYNC_N, 0);

        // Divider: first toggle (a rise) after div cycles, second after 2*div.
        for (int i = 0; i < 5; i++) begin
            div = dv[i].div;
            apply_reset();
            t1   = -1;
            t2   = -1;
            lvl  = 1'b0;
            prev = new_clk;
            for (int c = 1; c <= 4 * dv[i].half + 2; c++) begin
                @(negedge clk);
                if (new_clk !== prev) begin
                    if (t1 < 0) begin
                        t1  = c;
                        lvl = new_clk;
                    end else if (t2 < 0) begin
                        t2 = c;
                    end
                end
                prev = new_clk;
            end
            check($sformatf("div=%0d first toggle cycle", dv[i].div), t1, dv[i].half);
            check($sformatf("div=%0d first toggle rises", dv[i].div), lvl, 1);
            check($sformatf("div=%0d second toggle cycle", dv[i].div), t2, 2 * dv[i].half);
        end

        // Divisor cut from 1000 to 3 while the count sits at 500.
        div = 26'd1000;
        apply_reset();
        repeat (500) @(negedge clk);
        check("div 1000 no toggle by cnt=500", new_clk, 0);
        div = 26'd3;
        @(negedge clk);
        check("div cut wraps next cycle", new_clk, 1);
        prev = new_clk;
        t1   = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (new_clk !== prev) begin
                t1++;
                check($sformatf("div cut toggle %0d spacing", t1), c, 3 * t1);
            end
            prev = new_clk;
        end
        check("div cut toggle count", t1, 3);

        // Two frames per colour: per-sample model compare plus sync/blank measurements.
        div = 26'd4;
        for (int row = 0; row < 3; row++) begin
            red   = cv[row].r;
            green = cv[row].g;
            blue  = cv[row].b;
            apply_reset();
            p = 0;  bad = 0;  first_bad = -1;
            prev_vclk = VGA_CLK;  prev_hs = VGA_HS;  prev_vs = VGA_VS;  prev_bl = 1'b0;
            hs_f1 = -1; hs_f2 = -1; hs_r = -1; vs_f1 = -1; vs_f2 = -1; vs_r = -1;
            bl_pix = 0; bl_runs = 0; run = 0; max_run = 0;
            for (int n = 0; n < 2 * (2 * FRAME + 20); n++) begin
                @(negedge clk);
                rise      = VGA_CLK && !prev_vclk;
                prev_vclk = VGA_CLK;
                if (rise) p++;
                model(p, cv[row], e_hs, e_vs, e_bl, e_rgb);
                if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {e_hs, e_vs, e_bl, e_rgb}) begin
                    if (bad == 0) first_bad = p;
                    bad++;
                end
                if (prev_hs && !VGA_HS) begin
                    if (hs_f1 < 0) hs_f1 = p; else if (hs_f2 < 0) hs_f2 = p;
                end
                if (!prev_hs && VGA_HS && hs_f1 >= 0 && hs_r < 0) hs_r = p;
                if (prev_vs && !VGA_VS) begin
                    if (vs_f1 < 0) vs_f1 = p; else if (vs_f2 < 0) vs_f2 = p;
                end
                if (!prev_vs && VGA_VS && vs_f1 >= 0 && vs_r < 0) vs_r = p;
                prev_hs = VGA_HS;
                prev_vs = VGA_VS;
                if (rise && p <= FRAME) begin
                    if (VGA_BLANK_N === 1'b1) begin
                        bl_pix++;
                        run++;
                        if (!prev_bl) bl_runs++;
                        if (run > max_run) max_run = run;
                    end else begin
                        run = 0;
                    end
                    prev_bl = VGA_BLANK_N;
                end
            end
            check($sformatf("row%0d model mismatches (first at pixel %0d)", row, first_bad), bad, 0);
            check($sformatf("row%0d hsync low width", row), hs_r - hs_f1, HS);
            check($sformatf("row%0d hsync period", row), hs_f2 - hs_f1, HT);
            check($sformatf("row%0d vsync low width", row), vs_r - vs_f1, VS * HT);
            check($sformatf("row%0d vsync period", row), vs_f2 - vs_f1, FRAME);
            check($sformatf("row%0d blank-high pixels per frame", row), bl_pix, HV * VV);
            check($sformatf("row%0d blank-high lines", row), bl_runs, VV);
            check($sformatf("row%0d blank-high run length", row), max_run, HV);
            check($sformatf("row%0d sync_n", row), VGA_SYNC_N, 0);
        end

        // Reset asserted mid-frame inside the visible window.
        red   = 8'hAA;
        green = 8'h55;
        blue  = 8'hFF;
        apply_reset();
        p = 0;
        prev_vclk = VGA_CLK;
        for (int n = 0; n < 2 * TARGET + 4 && p < TARGET; n++) begin
            @(negedge clk);
            if (VGA_CLK && !prev_vclk) p++;
            prev_vclk = VGA_CLK;
        end
        check("mid-frame target reached", p, TARGET);
        model(TARGET, cv[0], e_hs, e_vs, e_bl, e_rgb);
        check("mid-frame outputs before reset", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B},
              {e_hs, e_vs, e_bl, e_rgb});
        reset = 1'b1;
        #1;
        check("mid-frame reset immediate", {new_clk, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, 64'h0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if ({new_clk, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== 64'h0) bad++;
        end
        check("mid-frame reset held", bad, 0);
        reset = 1'b0;
        @(negedge clk);
        check("first pixel clock rise one clk after release", VGA_CLK, 1);
        rises     = 1;
        prev_vclk = VGA_CLK;
        for (int n = 0; n < 4 * HT && VGA_HS !== 1'b1; n++) begin
            @(negedge clk);
            if (VGA_CLK && !prev_vclk) rises++;
            prev_vclk = VGA_CLK;
        end
        check("hsync release after restart (pixel rises)", rises, HS);
        check("vsync low after restart", VGA_VS, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
